// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit type codes, FSM states, buffer sizing and head-field packing.
package noc_pkg;

   // Flit type field encodings carried in the two most significant flit bits
   localparam logic [1:0] FLIT_BODY      = 2'b00;
   localparam logic [1:0] FLIT_HEAD      = 2'b01;
   localparam logic [1:0] FLIT_TAIL      = 2'b10;
   localparam logic [1:0] FLIT_HEAD_TAIL = 2'b11;

   // A flit is {type, dest, data}; type sits on top, data at bit 0
   localparam int FLIT_TYPE_W = 2;

   // Injector sequencing states
   typedef enum logic [1:0] {
      ST_IDLE,
      ST_HEAD,
      ST_BODY
   } inj_state_t;

   // Number of flit slots in one VC input buffer of the downstream node
   function automatic int buf_depth(input int buf_w, input int flit_w);
      return buf_w / flit_w;
   endfunction

   // Head payload: {source id, destination id, body length}, right aligned
   function automatic logic [31:0] pack_head(input int id_w, input int len_w,
                                             input logic [31:0] node,
                                             input logic [31:0] dest,
                                             input logic [31:0] len);
      return (node << (id_w + len_w)) | (dest << len_w) | len;
   endfunction

endpackage

// File: rtl/vc_credit_counter.sv
// Credit counter for one virtual channel: tracks free slots in the downstream VC buffer.
module vc_credit_counter
   import noc_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic inc,
   input  logic dec,
   output logic avail
);

   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [CNT_W-1:0] count;

   // Consume a credit per flit sent, regain one per returned slot; saturate at both ends
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count <= CNT_W'(DEPTH);
      end else if (inc && !dec) begin
         if (count != CNT_W'(DEPTH)) begin
            count <= count + 1'b1;
         end
      end else if (dec && !inc) begin
         if (count != '0) begin
            count <= count - 1'b1;
         end
      end
   end

   assign avail = (count != '0);

   // A credit returned while the counter is already full means the neighbour miscounted
   overflow_chk: assert property (@(posedge clk) disable iff (!reset)
      !(inc && !dec && count == CNT_W'(DEPTH)));

endmodule

// File: rtl/spidergon_flit_injector.sv
// Local-port injector: turns packet requests plus payload words into credit-gated flits.
module spidergon_flit_injector
   import noc_pkg::*;
#(
   parameter int NUM_OF_NODES            = 8,
   parameter int NODE_ID                 = 0,
   parameter int FLIT_DATA_WIDTH         = 16,
   parameter int NODE_BUFFER_WIDTH       = 32,
   parameter int NUM_OF_VIRTUAL_CHANNELS = 2,
   parameter int MAX_BODY_FLITS          = 7
) (
   input  logic                                                       clk,
   input  logic                                                       reset,
   input  logic                                                       pkt_valid,
   output logic                                                       pkt_ready,
   input  logic [$clog2(NUM_OF_NODES)-1:0]                            pkt_dest,
   input  logic [$clog2(MAX_BODY_FLITS+1)-1:0]                        pkt_len,
   input  logic                                                       data_valid,
   output logic                                                       data_ready,
   input  logic [FLIT_DATA_WIDTH-1:0]                                 data_in,
   output logic                                                       flit_valid,
   output logic [FLIT_TYPE_W+$clog2(NUM_OF_NODES)+FLIT_DATA_WIDTH-1:0] flit_out,
   output logic [$clog2(NUM_OF_VIRTUAL_CHANNELS)-1:0]                 flit_vc,
   input  logic [NUM_OF_VIRTUAL_CHANNELS-1:0]                         credit_in,
   output logic                                                       err_self
);

   localparam int ID_W      = $clog2(NUM_OF_NODES);
   localparam int LEN_W     = $clog2(MAX_BODY_FLITS + 1);
   localparam int VC_W      = $clog2(NUM_OF_VIRTUAL_CHANNELS);
   localparam int BUF_DEPTH = buf_depth(NODE_BUFFER_WIDTH, FLIT_DATA_WIDTH);

   inj_state_t state, state_nxt;

   logic [ID_W-1:0]            dest_q;
   logic [LEN_W-1:0]           len_q;
   logic [LEN_W-1:0]           rem_q, rem_nxt;
   logic [VC_W-1:0]            vc_q, vc_sel;
   logic                       accept, self_drop, send, vc_ok;
   logic [1:0]                 type_nxt;
   logic [FLIT_DATA_WIDTH-1:0] data_nxt, head_data;
   logic [NUM_OF_VIRTUAL_CHANNELS-1:0] credit_avail, credit_dec;

   // Packets heading "backwards" across node 0 ride VC1 so the ring has a dateline
   assign vc_sel    = (pkt_dest < ID_W'(NODE_ID)) ? VC_W'(1) : '0;
   assign head_data = FLIT_DATA_WIDTH'(pack_head(ID_W, LEN_W, 32'(NODE_ID),
                                                 32'(dest_q), 32'(len_q)));
   assign vc_ok     = credit_avail[vc_q];
   assign pkt_ready = (state == ST_IDLE);

   // One credit counter per VC; only the VC of the current packet is charged
   for (genvar v = 0; v < NUM_OF_VIRTUAL_CHANNELS; v++) begin : g_credit
      vc_credit_counter #(.DEPTH(BUF_DEPTH)) u_cnt (
         .clk   (clk),
         .reset (reset),
         .inc   (credit_in[v]),
         .dec   (credit_dec[v]),
         .avail (credit_avail[v])
      );
   end

   // Charge the active VC for every flit launched this cycle
   always_comb begin
      credit_dec = '0;
      for (int v = 0; v < NUM_OF_VIRTUAL_CHANNELS; v++) begin
         credit_dec[v] = send && (vc_q == VC_W'(v));
      end
   end

   // Sequencing: pick the next flit to launch, when it may go, and where the FSM goes next
   always_comb begin
      state_nxt  = state;
      accept     = 1'b0;
      self_drop  = 1'b0;
      send       = 1'b0;
      data_ready = 1'b0;
      type_nxt   = FLIT_BODY;
      data_nxt   = '0;
      rem_nxt    = rem_q;
      case (state)
         ST_IDLE: begin
            if (pkt_valid) begin
               accept = 1'b1;
               if (pkt_dest == ID_W'(NODE_ID)) begin
                  self_drop = 1'b1;
               end else begin
                  state_nxt = ST_HEAD;
               end
            end
         end
         ST_HEAD: begin
            if (vc_ok) begin
               send     = 1'b1;
               data_nxt = head_data;
               rem_nxt  = len_q;
               if (len_q == '0) begin
                  type_nxt  = FLIT_HEAD_TAIL;
                  state_nxt = ST_IDLE;
               end else begin
                  type_nxt  = FLIT_HEAD;
                  state_nxt = ST_BODY;
               end
            end
         end
         ST_BODY: begin
            if (vc_ok && data_valid) begin
               data_ready = 1'b1;
               send       = 1'b1;
               data_nxt   = data_in;
               rem_nxt    = rem_q - 1'b1;
               if (rem_q == LEN_W'(1)) begin
                  type_nxt  = FLIT_TAIL;
                  state_nxt = ST_IDLE;
               end else begin
                  type_nxt  = FLIT_BODY;
               end
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // FSM state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Latched packet fields and registered flit outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         dest_q     <= '0;
         len_q      <= '0;
         rem_q      <= '0;
         vc_q       <= '0;
         flit_valid <= 1'b0;
         flit_out   <= '0;
         flit_vc    <= '0;
         err_self   <= 1'b0;
      end else begin
         flit_valid <= send;
         err_self   <= self_drop;
         rem_q      <= rem_nxt;
         if (accept) begin
            dest_q <= pkt_dest;
            len_q  <= pkt_len;
            vc_q   <= vc_sel;
         end
         if (send) begin
            flit_out <= {type_nxt, dest_q, data_nxt};
            flit_vc  <= vc_q;
         end
      end
   end

endmodule

// File: tb/tb_spidergon_flit_injector.sv
// Self-checking bench: packet-level reference model with randomized traffic and credits.
module tb_spidergon_flit_injector;

   localparam int NID       = 2;
   localparam int ID_W      = 3;
   localparam int LEN_W     = 3;
   localparam int VC_W      = 1;
   localparam int DW        = 16;
   localparam int NVC       = 2;
   localparam int FLIT_W    = 2 + ID_W + DW;
   localparam int BUF_DEPTH = 2;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic              pkt_valid = 1'b0, pkt_ready;
   logic [ID_W-1:0]   pkt_dest = '0;
   logic [LEN_W-1:0]  pkt_len = '0;
   logic              data_valid = 1'b0, data_ready;
   logic [DW-1:0]     data_in = '0;
   logic              flit_valid;
   logic [FLIT_W-1:0] flit_out;
   logic [VC_W-1:0]   flit_vc;
   logic [NVC-1:0]    credit_in = '0;
   logic              err_self;

   logic              p5_valid = 1'b0, p5_ready;
   logic [ID_W-1:0]   p5_dest = '0;
   logic [LEN_W-1:0]  p5_len = '0;
   logic              d5_ready;
   logic              f5_valid;
   logic [FLIT_W-1:0] f5_out;
   logic [VC_W-1:0]   f5_vc;
   logic              e5_self;

   spidergon_flit_injector #(.NODE_ID(NID)) dut (
      .clk(clk), .reset(reset), .pkt_valid(pkt_valid), .pkt_ready(pkt_ready),
      .pkt_dest(pkt_dest), .pkt_len(pkt_len), .data_valid(data_valid),
      .data_ready(data_ready), .data_in(data_in), .flit_valid(flit_valid),
      .flit_out(flit_out), .flit_vc(flit_vc), .credit_in(credit_in), .err_self(err_self)
   );

   spidergon_flit_injector #(.NODE_ID(5)) dut5 (
      .clk(clk), .reset(reset), .pkt_valid(p5_valid), .pkt_ready(p5_ready),
      .pkt_dest(p5_dest), .pkt_len(p5_len), .data_valid(1'b0),
      .data_ready(d5_ready), .data_in(16'h0000), .flit_valid(f5_valid),
      .flit_out(f5_out), .flit_vc(f5_vc), .credit_in(2'b00), .err_self(e5_self)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int n_flits = 0;
   logic [FLIT_W-1:0] exp_q[$];
   logic [VC_W-1:0]   exp_vc_q[$];
   logic [FLIT_W-1:0] flit_log[$];
   logic [VC_W-1:0]   vc_log[$];
   int                cyc_log[$];
   logic [DW-1:0]     pay_q[$];
   logic [DW-1:0]     next_pay[$];
   int outstanding[NVC];
   int credit_req[NVC];
   bit credit_auto = 1'b0;
   int credit_prob = 100;
   int data_prob = 100;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [FLIT_W-1:0] mk_flit(input logic [1:0] t, input int dest, input int data);
      return {t, 3'(dest), 16'(data)};
   endfunction

   // Downstream node model: checks each flit against the expected stream, tracks buffer occupancy,
   // returns credits, and notes payload words the injector takes
   initial begin
      forever begin
         @(negedge clk);
         credit_in = '0;
         if (reset) begin
            if (data_ready) begin
               check("data_ready_needs_valid", 32'(data_valid), 32'd1);
               if (pay_q.size() > 0) void'(pay_q.pop_front());
            end
            if (flit_valid) begin
               n_flits++;
               flit_log.push_back(flit_out);
               vc_log.push_back(flit_vc);
               cyc_log.push_back(cyc);
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("[TB] FAIL unexpected_flit: got 0x%0h expected none", flit_out);
               end else begin
                  check("flit_out", 32'(flit_out), 32'(exp_q.pop_front()));
                  check("flit_vc", 32'(flit_vc), 32'(exp_vc_q.pop_front()));
               end
               check("slot_free_when_sent", 32'(outstanding[flit_vc] < BUF_DEPTH), 32'd1);
               outstanding[flit_vc]++;
            end
            for (int v = 0; v < NVC; v++) begin
               if (outstanding[v] > 0 &&
                   (credit_req[v] > 0 || (credit_auto && $urandom_range(99) < credit_prob))) begin
                  credit_in[v] = 1'b1;
                  outstanding[v]--;
                  if (credit_req[v] > 0) credit_req[v]--;
               end
            end
         end
      end
   end

   // Core-side payload source: offers the next queued word with random gaps
   initial begin
      forever begin
         step();
         if (pay_q.size() > 0 && $urandom_range(99) < data_prob) begin
            data_valid = 1'b1;
            data_in    = pay_q[0];
         end else begin
            data_valid = 1'b0;
            data_in    = 16'($urandom);
         end
      end
   end

   // Issue one packet request and enqueue the flits it must produce
   task automatic send_pkt(input int dest, input int len, output int acc_cyc);
      int guard = 0;
      acc_cyc = -1;
      if (dest != NID) begin
         exp_q.push_back(mk_flit(len == 0 ? 2'b11 : 2'b01, dest, NID * 64 + dest * 8 + len));
         exp_vc_q.push_back(VC_W'(dest < NID));
         for (int i = 0; i < len; i++) begin
            logic [DW-1:0] p;
            p = (next_pay.size() > 0) ? next_pay.pop_front() : DW'($urandom);
            pay_q.push_back(p);
            exp_q.push_back(mk_flit(i == len - 1 ? 2'b10 : 2'b00, dest, p));
            exp_vc_q.push_back(VC_W'(dest < NID));
         end
      end
      pkt_valid = 1'b1;
      pkt_dest  = ID_W'(dest);
      pkt_len   = LEN_W'(len);
      do begin
         @(negedge clk);
         guard++;
      end while (!pkt_ready && guard < 2000);
      if (!pkt_ready) begin
         checks++;
         errors++;
         $display("[TB] FAIL pkt_accept_timeout: got pkt_ready 0 expected 1");
         pkt_valid = 1'b0;
         return;
      end
      step();
      acc_cyc   = cyc;
      pkt_valid = 1'b0;
      if (dest == NID) begin
         check("err_self_pulse", 32'(err_self), 32'd1);
         step();
         check("err_self_one_cycle", 32'(err_self), 32'd0);
      end else begin
         check("err_self_quiet", 32'(err_self), 32'd0);
      end
   endtask

   task automatic drain(input string name);
      int g = 0;
      while ((exp_q.size() != 0 || !pkt_ready) && g < 3000) begin
         step();
         g++;
      end
      check(name, 32'(exp_q.size() == 0 && pkt_ready), 32'd1);
      repeat (6) step();
   endtask

   initial begin
      #400000;
      errors++;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int acc, n0, idx;

      repeat (2) step();
      check("reset_pkt_ready_held", 32'(pkt_ready), 32'd1);
      check("reset_flit_valid_held", 32'(flit_valid), 32'd0);
      reset = 1'b1;
      step();
      check("rst_pkt_ready", 32'(pkt_ready), 32'd1);
      check("rst_flit_valid", 32'(flit_valid), 32'd0);
      check("rst_flit_out", 32'(flit_out), 32'd0);
      check("rst_flit_vc", 32'(flit_vc), 32'd0);
      check("rst_err_self", 32'(err_self), 32'd0);
      check("rst_data_ready", 32'(data_ready), 32'd0);

      // Node 5 sending to node 1: single flit on VC1 carrying {5,1,0}
      p5_valid = 1'b1;
      p5_dest  = 3'd1;
      p5_len   = 3'd0;
      step();
      p5_valid = 1'b0;
      step();
      check("n5_head_tail_valid", 32'(f5_valid), 32'd1);
      check("n5_head_tail_flit", 32'(f5_out), 32'({2'b11, 3'd1, 16'h0148}));
      check("n5_head_tail_vc", 32'(f5_vc), 32'd1);
      step();
      check("n5_single_cycle", 32'(f5_valid), 32'd0);

      // No credits returned: the two fresh VC0 credits allow exactly two flits
      n0 = n_flits;
      send_pkt(5, 3, acc);
      repeat (10) step();
      check("stall_after_two", 32'(n_flits - n0), 32'd2);
      check("stall_data_ready_low", 32'(data_ready), 32'd0);
      credit_req[0] = 1;
      repeat (5) step();
      check("one_credit_one_flit", 32'(n_flits - n0), 32'd3);
      credit_req[0] = 1;
      repeat (5) step();
      check("tail_after_credit", 32'(n_flits - n0), 32'd4);
      check("idle_after_tail", 32'(pkt_ready), 32'd1);

      // VC1 still has both credits while VC0 is exhausted
      n0  = n_flits;
      idx = flit_log.size();
      send_pkt(1, 1, acc);
      repeat (5) step();
      check("vc1_unaffected", 32'(n_flits - n0), 32'd2);
      if (n_flits - n0 == 2) begin
         check("vc1_head_flit", 32'(flit_log[idx]), 32'({2'b01, 3'd1, 16'h0089}));
         check("vc1_head_vc", 32'(vc_log[idx]), 32'd1);
         check("vc1_head_latency", 32'(cyc_log[idx] - acc), 32'd1);
         check("vc1_back_to_back", 32'(cyc_log[idx+1] - cyc_log[idx]), 32'd1);
      end
      credit_req[0] = 2;
      credit_req[1] = 2;
      repeat (6) step();

      // Credit returned in the same cycle a VC0 flit goes out leaves the count unchanged
      send_pkt(5, 0, acc);
      repeat (4) step();
      n0 = n_flits;
      send_pkt(5, 2, acc);
      credit_req[0] = 1;
      repeat (8) step();
      check("same_cycle_inc_dec", 32'(n_flits - n0), 32'd2);
      credit_auto = 1'b1;
      drain("drain_same_cycle");

      // Node 2 to node 5, two body words, credits returned at once: three back-to-back flits
      next_pay.push_back(16'hAAAA);
      next_pay.push_back(16'hBBBB);
      idx = flit_log.size();
      send_pkt(5, 2, acc);
      drain("drain_example");
      check("ex_flit_count", 32'(flit_log.size() - idx), 32'd3);
      if (flit_log.size() - idx == 3) begin
         check("ex_head", 32'(flit_log[idx]), 32'({2'b01, 3'd5, 16'h00AA}));
         check("ex_body", 32'(flit_log[idx+1]), 32'({2'b00, 3'd5, 16'hAAAA}));
         check("ex_tail", 32'(flit_log[idx+2]), 32'({2'b10, 3'd5, 16'hBBBB}));
         check("ex_vc", 32'(vc_log[idx] | vc_log[idx+1] | vc_log[idx+2]), 32'd0);
         check("ex_head_latency", 32'(cyc_log[idx] - acc), 32'd1);
         check("ex_body_next", 32'(cyc_log[idx+1] - acc), 32'd2);
         check("ex_tail_next", 32'(cyc_log[idx+2] - acc), 32'd3);
      end

      // Request addressed to this node is dropped with no flits
      n0 = n_flits;
      send_pkt(NID, 3, acc);
      repeat (6) step();
      check("self_no_flits", 32'(n_flits - n0), 32'd0);
      check("self_ready", 32'(pkt_ready), 32'd1);

      // Randomized traffic with gappy data and lazy credit return
      credit_prob = 40;
      data_prob   = 70;
      for (int k = 0; k < 40; k++) begin
         send_pkt($urandom_range(7), $urandom_range(7), acc);
         if ($urandom_range(3) == 0) repeat ($urandom_range(4)) step();
      end
      drain("drain_random");
      check("payload_all_used", 32'(pay_q.size()), 32'd0);

      // Reset in the middle of a body burst abandons the packet
      credit_prob = 100;
      data_prob   = 100;
      n0 = n_flits;
      send_pkt(6, 5, acc);
      for (int g = 0; g < 50 && n_flits - n0 < 2; g++) step();
      @(posedge clk);
      #3;
      check("pre_reset_streaming", 32'(flit_valid), 32'd1);
      reset = 1'b0;
      #1;
      check("reset_drops_valid", 32'(flit_valid), 32'd0);
      check("reset_ready", 32'(pkt_ready), 32'd1);
      exp_q.delete();
      exp_vc_q.delete();
      pay_q.delete();
      next_pay.delete();
      for (int v = 0; v < NVC; v++) begin
         outstanding[v] = 0;
         credit_req[v]  = 0;
      end
      repeat (2) step();
      reset = 1'b1;
      step();
      idx = flit_log.size();
      send_pkt(3, 1, acc);
      drain("drain_after_reset");
      check("post_reset_count", 32'(flit_log.size() - idx), 32'd2);
      if (flit_log.size() - idx >= 1) begin
         check("post_reset_head", 32'(flit_log[idx]), 32'({2'b01, 3'd3, 16'h0099}));
         check("post_reset_latency", 32'(cyc_log[idx] - acc), 32'd1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
